// File: rtl/axis_pkt_arbiter_2to1.sv
// ----------------------------------------------------------------------------
// axis_pkt_arbiter_2to1
//
// Packet-level 2:1 AXI-Stream arbiter. Two slave streams (A, B) compete for a
// single master stream. Ownership is granted per packet: once an input wins
// arbitration it keeps the output until its tlast beat is accepted, then the
// arbiter returns to IDLE for one dead cycle before the next decision.
//
// Arbitration modes (sampled only in IDLE):
//   prio_mode = 0 : round-robin, a tie goes to the input that did not own the
//                   most recently completed packet.
//   prio_mode = 1 : fixed priority, A wins every tie.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   s_axis_*_A / s_axis_*_B  AXI-Stream slave inputs A and B
//   m_axis_*               AXI-Stream master output (one register stage)
//   prio_mode              arbitration mode select
//   grant                  one-hot owner, bit0 = A, bit1 = B, 2'b00 when idle
//   pkt_count_A/B          wrapping count of packets forwarded per input
// ----------------------------------------------------------------------------
module axis_pkt_arbiter_2to1 #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata_A,
  input  logic                  s_axis_tvalid_A,
  output logic                  s_axis_tready_A,
  input  logic                  s_axis_tlast_A,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata_B,
  input  logic                  s_axis_tvalid_B,
  output logic                  s_axis_tready_B,
  input  logic                  s_axis_tlast_B,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,

  input  logic                  prio_mode,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  pkt_count_A,
  output logic [CNT_WIDTH-1:0]  pkt_count_B
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  // Encoding of the last-owner flag.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  state_t                state_reg;
  state_t                state_next;
  logic                  last_grant_reg;
  logic                  last_grant_next;

  logic                  ready;
  logic                  accept;
  logic                  accept_last_a;
  logic                  accept_last_b;
  logic [DATA_WIDTH-1:0] accept_data;
  logic                  accept_last;

  // The output register can take a new beat when it is empty or draining.
  assign ready = !m_axis_tvalid || m_axis_tready;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= SRC_B;   // so A wins the first tie after reset
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state, slave handshakes and beat selection
  // --------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    s_axis_tready_A = 1'b0;
    s_axis_tready_B = 1'b0;
    accept          = 1'b0;
    accept_last_a   = 1'b0;
    accept_last_b   = 1'b0;
    accept_data     = '0;
    accept_last     = 1'b0;

    case (state_reg)
      IDLE: begin
        // Arbitration cycle only: nothing is accepted here.
        if (s_axis_tvalid_A && s_axis_tvalid_B) begin
          if (prio_mode || (last_grant_reg == SRC_B)) begin
            state_next = GRANT_A;
          end else begin
            state_next = GRANT_B;
          end
        end else if (s_axis_tvalid_A) begin
          state_next = GRANT_A;
        end else if (s_axis_tvalid_B) begin
          state_next = GRANT_B;
        end
      end

      GRANT_A: begin
        s_axis_tready_A = ready;
        accept_data     = s_axis_tdata_A;
        accept_last     = s_axis_tlast_A;
        if (s_axis_tvalid_A && ready) begin
          accept = 1'b1;
          if (s_axis_tlast_A) begin
            accept_last_a   = 1'b1;
            last_grant_next = SRC_A;
            state_next      = IDLE;
          end
        end
      end

      GRANT_B: begin
        s_axis_tready_B = ready;
        accept_data     = s_axis_tdata_B;
        accept_last     = s_axis_tlast_B;
        if (s_axis_tvalid_B && ready) begin
          accept = 1'b1;
          if (s_axis_tlast_B) begin
            accept_last_b   = 1'b1;
            last_grant_next = SRC_B;
            state_next      = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output register stage. Data/last hold when no new beat is loaded so the
  // bus stays stable under backpressure.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (accept) begin
      m_axis_tdata  <= accept_data;
      m_axis_tlast  <= accept_last;
      m_axis_tvalid <= 1'b1;
    end else if (ready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Grant is registered from the next state, so it always matches the state
  // register and rises in the cycle the FSM enters GRANT_x.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant <= 2'b00;
    end else begin
      grant <= {state_next == GRANT_B, state_next == GRANT_A};
    end
  end

  // --------------------------------------------------------------------------
  // Per-input packet counters, naturally wrapping.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_count_A <= '0;
      pkt_count_B <= '0;
    end else begin
      if (accept_last_a) begin
        pkt_count_A <= pkt_count_A + CNT_WIDTH'(1);
      end
      if (accept_last_b) begin
        pkt_count_B <= pkt_count_B + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter_2to1.sv
// ----------------------------------------------------------------------------
// Testbench for axis_pkt_arbiter_2to1 (CNT_WIDTH = 4 so counter wrap is cheap).
// Stimulus tasks push hand-ordered expected beats into a scoreboard queue; a
// separate monitor pops and compares every beat the DUT transfers.
// ----------------------------------------------------------------------------
module tb_axis_pkt_arbiter_2to1;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] sa_data = '0;
  logic          sa_valid = 1'b0;
  logic          sa_ready;
  logic          sa_last = 1'b0;
  logic [DW-1:0] sb_data = '0;
  logic          sb_valid = 1'b0;
  logic          sb_ready;
  logic          sb_last = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          prio_mode = 1'b0;
  logic [1:0]    grant;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  always #5 clk = ~clk;

  axis_pkt_arbiter_2to1 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .s_axis_tdata_A  (sa_data),
    .s_axis_tvalid_A (sa_valid),
    .s_axis_tready_A (sa_ready),
    .s_axis_tlast_A  (sa_last),
    .s_axis_tdata_B  (sb_data),
    .s_axis_tvalid_B (sb_valid),
    .s_axis_tready_B (sb_ready),
    .s_axis_tlast_B  (sb_last),
    .m_axis_tdata    (m_data),
    .m_axis_tvalid   (m_valid),
    .m_axis_tready   (m_ready),
    .m_axis_tlast    (m_last),
    .prio_mode       (prio_mode),
    .grant           (grant),
    .pkt_count_A     (cnt_a),
    .pkt_count_B     (cnt_b)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [7:0]    gap;   // idle cycles before this beat is offered
  } src_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  src_t qa[$];
  src_t qb[$];
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic a_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_a(input logic [DW-1:0] d, input logic l, input logic [7:0] gap);
    qa.push_back('{d: d, l: l, gap: gap});
  endtask

  task automatic push_b(input logic [DW-1:0] d, input logic l, input logic [7:0] gap);
    qb.push_back('{d: d, l: l, gap: gap});
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic l);
    exp_q.push_back('{d: d, l: l});
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive queued beats on A; each beat held until a cycle with tready_A high.
  task automatic run_a();
    src_t b;
    int   n;
    bit   ok;
    while (qa.size() > 0) begin
      b = qa.pop_front();
      if (b.gap != 0) begin
        sa_valid = 1'b0;
        idle_cycles(int'(b.gap));
      end
      sa_data  = b.d;
      sa_last  = b.l;
      sa_valid = 1'b1;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 200) begin
        @(negedge clk);
        if (sa_ready) ok = 1'b1;
        n++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL a_accept_timeout: got no tready required tready for 0x%0h", b.d);
        qa.delete();
      end
      @(posedge clk);
      #1;
    end
    sa_valid = 1'b0;
    sa_last  = 1'b0;
  endtask

  task automatic run_b();
    src_t b;
    int   n;
    bit   ok;
    while (qb.size() > 0) begin
      b = qb.pop_front();
      if (b.gap != 0) begin
        sb_valid = 1'b0;
        idle_cycles(int'(b.gap));
      end
      sb_data  = b.d;
      sb_last  = b.l;
      sb_valid = 1'b1;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 200) begin
        @(negedge clk);
        if (sb_ready) ok = 1'b1;
        n++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL b_accept_timeout: got no tready required tready for 0x%0h", b.d);
        qb.delete();
      end
      @(posedge clk);
      #1;
    end
    sb_valid = 1'b0;
    sb_last  = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then check the counters.
  task automatic drain(input logic [CW-1:0] exp_a, input logic [CW-1:0] exp_b);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    idle_cycles(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("pkt_count_A", 32'(cnt_a), 32'(exp_a));
    check("pkt_count_B", 32'(cnt_b), 32'(exp_b));
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_m_tvalid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_tlast"}, 32'(m_last), 32'd0);
    check({tag, "_m_tdata"}, m_data, 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_cnt_a"}, 32'(cnt_a), 32'd0);
    check({tag, "_cnt_b"}, 32'(cnt_b), 32'd0);
    check({tag, "_tready_a"}, 32'(sa_ready), 32'd0);
    check({tag, "_tready_b"}, 32'(sb_ready), 32'd0);
  endtask

  // Scoreboard monitor: one compare per transferred output beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%0h last %0d required none", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          $display("beat data=0x%0h last=%0d (expected 0x%0h last=%0d)", m_data, m_last, e.d, e.l);
          check("beat_data", m_data, e.d);
          check("beat_last", 32'(m_last), 32'(e.l));
        end
      end
    end
  end

  initial begin
    int n;

    // ---------------- reset values ----------------
    idle_cycles(3);
    check_reset_values("reset");
    resetn = 1'b1;
    idle_cycles(2);

    // ---------------- single source A ----------------
    push_a(32'h11, 1'b0, 8'd0);
    push_a(32'h22, 1'b0, 8'd0);
    push_a(32'h33, 1'b1, 8'd0);
    expect_beat(32'h11, 1'b0);
    expect_beat(32'h22, 1'b0);
    expect_beat(32'h33, 1'b1);
    fork
      run_a();
      begin
        @(negedge clk);
        check("single_arb_grant", 32'(grant), 32'd0);
        check("single_arb_tready", 32'(sa_ready), 32'd0);
        @(negedge clk);
        check("single_grant", 32'(grant), 32'd1);
        @(negedge clk);
        check("single_latency", m_data, 32'h11);
      end
    join
    drain(4'd1, 4'd0);

    // ---------------- round-robin tie (last owner A, so B first) ----------------
    prio_mode = 1'b0;
    for (int p = 0; p < 2; p++) begin
      push_a(32'hA0 + 32'(p * 2), 1'b0, 8'd0);
      push_a(32'hA1 + 32'(p * 2), 1'b1, 8'd0);
      push_b(32'hB0 + 32'(p * 2), 1'b0, 8'd0);
      push_b(32'hB1 + 32'(p * 2), 1'b1, 8'd0);
    end
    expect_beat(32'hB0, 1'b0); expect_beat(32'hB1, 1'b1);
    expect_beat(32'hA0, 1'b0); expect_beat(32'hA1, 1'b1);
    expect_beat(32'hB2, 1'b0); expect_beat(32'hB3, 1'b1);
    expect_beat(32'hA2, 1'b0); expect_beat(32'hA3, 1'b1);
    fork
      run_a();
      run_b();
    join
    drain(4'd3, 4'd2);

    // ---------------- fixed priority ----------------
    prio_mode = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push_a(32'h100 + 32'(p * 2), 1'b0, 8'd0);
      push_a(32'h101 + 32'(p * 2), 1'b1, 8'd0);
      expect_beat(32'h100 + 32'(p * 2), 1'b0);
      expect_beat(32'h101 + 32'(p * 2), 1'b1);
    end
    push_b(32'h200, 1'b0, 8'd0);
    push_b(32'h201, 1'b1, 8'd0);
    expect_beat(32'h200, 1'b0);
    expect_beat(32'h201, 1'b1);
    a_busy = 1'b1;
    fork
      begin
        run_a();
        a_busy = 1'b0;
        check("prio_cnt_b_unchanged", 32'(cnt_b), 32'd2);
      end
      run_b();
      begin
        while (a_busy) begin
          @(negedge clk);
          if (a_busy) check("prio_tready_b_low", 32'(sb_ready), 32'd0);
        end
      end
    join
    drain(4'd6, 4'd3);

    // ---------------- backpressure ----------------
    prio_mode = 1'b0;
    push_a(32'hC0, 1'b0, 8'd0);
    push_a(32'hC1, 1'b0, 8'd0);
    push_a(32'hC2, 1'b0, 8'd0);
    push_a(32'hC3, 1'b1, 8'd0);
    expect_beat(32'hC0, 1'b0);
    expect_beat(32'hC1, 1'b0);
    expect_beat(32'hC2, 1'b0);
    expect_beat(32'hC3, 1'b1);
    fork
      run_a();
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m_valid && n < 50);
        check("bp_first_valid", 32'(m_valid), 32'd1);
        @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_hold_data", m_data, 32'hC1);
          check("bp_hold_valid", 32'(m_valid), 32'd1);
          check("bp_hold_last", 32'(m_last), 32'd0);
          check("bp_tready_a", 32'(sa_ready), 32'd0);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain(4'd7, 4'd3);

    // ---------------- owner gap with B waiting ----------------
    prio_mode = 1'b1;
    push_a(32'hD0, 1'b0, 8'd0);
    push_a(32'hD1, 1'b0, 8'd3);
    push_a(32'hD2, 1'b1, 8'd0);
    push_b(32'hE0, 1'b1, 8'd0);
    expect_beat(32'hD0, 1'b0);
    expect_beat(32'hD1, 1'b0);
    expect_beat(32'hD2, 1'b1);
    expect_beat(32'hE0, 1'b1);
    fork
      run_a();
      run_b();
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(grant == 2'b01 && !sa_valid) && n < 50);
        for (int i = 0; i < 3; i++) begin
          if (i != 0) @(negedge clk);
          check("gap_grant", 32'(grant), 32'd1);
          check("gap_tready_b", 32'(sb_ready), 32'd0);
        end
      end
    join
    drain(4'd8, 4'd4);
    prio_mode = 1'b0;

    // ---------------- reset mid-packet ----------------
    m_ready  = 1'b0;
    sa_data  = 32'h51;
    sa_last  = 1'b0;
    sa_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sa_ready && n < 20);
    check("rst_first_accept", 32'(sa_ready), 32'd1);
    @(posedge clk);
    #1 sa_data = 32'h52;
    @(negedge clk);
    check("rst_pre_valid", 32'(m_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check_reset_values("midrst");
    sa_valid = 1'b0;
    idle_cycles(2);
    resetn  = 1'b1;
    m_ready = 1'b1;
    idle_cycles(2);
    check("post_rst_valid", 32'(m_valid), 32'd0);

    // ---------------- first tie after reset goes to A ----------------
    push_a(32'hF1, 1'b1, 8'd0);
    push_b(32'hF2, 1'b1, 8'd0);
    expect_beat(32'hF1, 1'b1);
    expect_beat(32'hF2, 1'b1);
    fork
      run_a();
      run_b();
    join
    drain(4'd1, 4'd1);

    // ---------------- counter wrap: 15 more A packets -> 16 total ----------------
    for (int p = 0; p < 15; p++) begin
      push_a(32'h300 + 32'(p), 1'b1, 8'd0);
      expect_beat(32'h300 + 32'(p), 1'b1);
    end
    run_a();
    drain(4'd0, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_pkt_arbiter_2to1.md
AXIS_PKT_ARBITER_2TO1 -- requirements
Module: axis_pkt_arbiter_2to1

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the tdata width of all streams.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of each packet counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports s_axis_tdata_A / s_axis_tvalid_A / s_axis_tready_A / s_axis_tlast_A  in/in/out/in  DATA_WIDTH/1/1/1  AXI-Stream slave A.
REQ-006 SHALL have ports s_axis_tdata_B / s_axis_tvalid_B / s_axis_tready_B / s_axis_tlast_B  in/in/out/in  DATA_WIDTH/1/1/1  AXI-Stream slave B.
REQ-007 SHALL have ports m_axis_tdata / m_axis_tvalid / m_axis_tready / m_axis_tlast  out/out/in/out  DATA_WIDTH/1/1/1  AXI-Stream master.
REQ-008 SHALL have port prio_mode  input  1  0 = round-robin, 1 = fixed priority to A.
REQ-009 SHALL have port grant  output  2  one-hot owner, bit0 = A, bit1 = B; 2'b00 when idle.
REQ-010 SHALL have ports pkt_count_A / pkt_count_B  output  CNT_WIDTH  packets forwarded per input.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT_A, GRANT_B.
REQ-012 In IDLE, s_axis_tready_A and s_axis_tready_B SHALL both be 0.
REQ-013 In IDLE with only A (B) valid, next state SHALL be GRANT_A (GRANT_B); no beat is accepted in the arbitration cycle.
REQ-014 In IDLE with both valid: prio_mode=1 -> GRANT_A; prio_mode=0 -> grant the input not in last_grant.
REQ-015 last_grant SHALL update to the owner on the accepted tlast beat; its reset value is B, so A wins the first tie.
REQ-016 Output stage SHALL be a single register stage; ready = !m_axis_tvalid | m_axis_tready.
REQ-017 In GRANT_x, s_axis_tready_x SHALL equal ready; the non-granted tready SHALL be 0.
REQ-018 A beat is accepted when the granted tvalid and tready are both 1; tdata/tlast SHALL be registered and m_axis_tvalid set on the next cycle (latency 1).
REQ-019 When ready=1 and no beat is accepted, m_axis_tvalid SHALL clear; when ready=0, m_axis_tdata/tlast/tvalid SHALL hold.
REQ-020 Grant SHALL persist across gaps in the owner's tvalid until its tlast beat is accepted (no mid-packet switch).
REQ-021 On an accepted tlast beat, next state SHALL be IDLE, giving a minimum of one dead cycle between packets.
REQ-022 pkt_count_x SHALL increment by 1 on each accepted tlast beat from x, wrapping from all-ones to 0.
REQ-023 A change of prio_mode SHALL affect only the next IDLE arbitration, never a granted packet.
REQ-024 grant SHALL be a registered decode of the FSM state.

Reset
REQ-025 While resetn=0: state IDLE, last_grant=B, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, grant=0, both counters 0, both s_axis_tready=0.
REQ-026 Reset asserted mid-packet SHALL discard the partial packet, the registered beat and the grant; after release, arbitration restarts from IDLE.

Verification
REQ-027 Single source: A sends 3 beats 0x11,0x22,0x33 (tlast on 0x33), m_axis_tready=1 -> grant=01 one cycle after tvalid; output beats in order, each 1 cycle after acceptance; tlast on 0x33; pkt_count_A=1.
REQ-028 Round-robin tie: A and B continuously offer 2-beat packets, prio_mode=0 -> packets alternate A,B,A,B; no interleaving; pkt_count_A=pkt_count_B after an even number of packets.
REQ-029 Fixed priority: same stimulus with prio_mode=1 -> only A packets forwarded; s_axis_tready_B=0 throughout; pkt_count_B=0.
REQ-030 Backpressure: m_axis_tready=0 for 5 cycles mid-packet -> m_axis_tdata/tvalid/tlast stable; s_axis_tready_A=0 while output full; no beat lost or duplicated.
REQ-031 Owner gap: A drops tvalid for 3 cycles mid-packet while B is valid -> grant stays 01; B not accepted until A's tlast is accepted.
REQ-032 Reset mid-packet plus counter wrap: resetn low during beat 2 -> all REQ-025 values; separately, preload with CNT_WIDTH=4 and send 16 packets on A -> pkt_count_A returns to 0.
